// File: rtl/raisin64_pkg.sv
// Shared raisin64 definitions used by the memory bus arbiter.
// Holds the access-width encodings, the arbiter state type and the
// requester tag type latched with each bus transaction.
package raisin64_pkg;

  localparam logic [1:0] WIDTH_BYTE  = 2'b00;
  localparam logic [1:0] WIDTH_HALF  = 2'b01;
  localparam logic [1:0] WIDTH_WORD  = 2'b10;
  localparam logic [1:0] WIDTH_DWORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    IBUS = 2'b01,
    DBUS = 2'b10,
    RESP = 2'b11
  } arb_state_t;

  typedef enum logic {
    TAG_I = 1'b0,
    TAG_D = 1'b1
  } req_tag_t;

endpackage

// File: rtl/membus_arbiter.sv
// membus_arbiter: shares one external memory bus between the fetch port
// (imem) and the data port (dmem). Data wins arbitration, but after
// STARVE_LIMIT consecutive data grants with a fetch waiting, the fetch is
// forced through. A fetch whose address changed or was withdrawn while on
// the bus is silently dropped.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   imem_addr/_valid      fetch request (level)
//   imem_data/_valid      fetch data and one-cycle completion pulse
//   dmem_addr/_dout       data address and store data
//   dmem_write_width      access width (00 byte .. 11 dword)
//   dmem_rstrobe/wstrobe  load / store request (level)
//   dmem_din              load data to the CPU
//   dmem_cycle_complete   one-cycle data completion pulse
//   bus_addr/wdata/width  external bus request, driven from latched values
//   bus_rd/bus_wr         external strobes, held until bus_ack
//   bus_rdata/bus_ack     external read data and single-cycle completion
module membus_arbiter
  import raisin64_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] imem_addr,
  input  logic        imem_addr_valid,
  output logic [63:0] imem_data,
  output logic        imem_data_valid,
  input  logic [63:0] dmem_addr,
  input  logic [63:0] dmem_dout,
  input  logic [1:0]  dmem_write_width,
  input  logic        dmem_rstrobe,
  input  logic        dmem_wstrobe,
  output logic [63:0] dmem_din,
  output logic        dmem_cycle_complete,
  output logic [63:0] bus_addr,
  output logic [63:0] bus_wdata,
  output logic [1:0]  bus_width,
  output logic        bus_rd,
  output logic        bus_wr,
  input  logic [63:0] bus_rdata,
  input  logic        bus_ack
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  arb_state_t state_r;
  arb_state_t state_nxt_s;
  req_tag_t   req_tag_r;
  logic [3:0] starve_cnt_r;
  logic       d_req_s;
  logic       starved_s;
  logic       grant_i_s;
  logic       grant_d_s;
  logic       ack_s;
  logic       fetch_hit_s;

  // Next-state and grant decode.
  always_comb begin
    state_nxt_s = state_r;
    grant_i_s   = 1'b0;
    grant_d_s   = 1'b0;
    ack_s       = 1'b0;
    d_req_s     = dmem_rstrobe | dmem_wstrobe;
    // Fetch is forced through once it has watched STARVE_LIMIT data grants.
    starved_s   = (starve_cnt_r == STARVE_MAX) && imem_addr_valid;
    // The fetch result is only wanted if the CPU still asks for that address.
    fetch_hit_s = imem_addr_valid && (imem_addr == bus_addr);
    case (state_r)
      IDLE: begin
        if (d_req_s && !starved_s) begin
          grant_d_s   = 1'b1;
          state_nxt_s = DBUS;
        end else if (imem_addr_valid) begin
          grant_i_s   = 1'b1;
          state_nxt_s = IBUS;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      IBUS, DBUS: begin
        if (bus_ack) begin
          ack_s       = 1'b1;
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = state_r;
        end
      end
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Starvation counter: counts data grants that a waiting fetch has watched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_r <= 4'd0;
    end else if (!imem_addr_valid || grant_i_s) begin
      starve_cnt_r <= 4'd0;
    end else if (grant_d_s && (starve_cnt_r != STARVE_MAX)) begin
      starve_cnt_r <= starve_cnt_r + 4'd1;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // Bus request latch: captured on grant, strobes dropped on ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_addr  <= 64'd0;
      bus_wdata <= 64'd0;
      bus_width <= 2'b00;
      bus_rd    <= 1'b0;
      bus_wr    <= 1'b0;
      req_tag_r <= TAG_I;
    end else if (grant_i_s) begin
      bus_addr  <= imem_addr;
      bus_wdata <= 64'd0;
      bus_width <= WIDTH_DWORD;
      bus_rd    <= 1'b1;
      bus_wr    <= 1'b0;
      req_tag_r <= TAG_I;
    end else if (grant_d_s) begin
      // A store wins over a simultaneous (illegal) load.
      bus_addr  <= dmem_addr;
      bus_wdata <= dmem_dout;
      bus_width <= dmem_write_width;
      bus_rd    <= ~dmem_wstrobe;
      bus_wr    <= dmem_wstrobe;
      req_tag_r <= TAG_D;
    end else if (ack_s) begin
      bus_rd    <= 1'b0;
      bus_wr    <= 1'b0;
    end
  end

  // Response side: completion pulses and held return data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_data           <= 64'd0;
      imem_data_valid     <= 1'b0;
      dmem_din            <= 64'd0;
      dmem_cycle_complete <= 1'b0;
    end else begin
      imem_data_valid     <= 1'b0;
      dmem_cycle_complete <= 1'b0;
      if (ack_s) begin
        if (req_tag_r == TAG_I) begin
          if (fetch_hit_s) begin
            imem_data       <= bus_rdata;
            imem_data_valid <= 1'b1;
          end
        end else begin
          dmem_cycle_complete <= 1'b1;
          if (!bus_wr) begin
            dmem_din <= bus_rdata;
          end
        end
      end
    end
  end

endmodule

// File: doc/membus_arbiter.md
# membus_arbiter

Shares one external memory bus between the fetch stage's instruction port and the memory execution unit's data port. The CPU can then run on a single-ported RAM or cache. Sits between the pipeline's imem/dmem ports and the external bus. Data accesses have priority, with a bounded-starvation guarantee for fetch. Stale fetches after a jump are discarded.

## Interface
- STARVE_LIMIT, 4: consecutive dmem grants allowed while imem is waiting, before imem is forced through (1..15).
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- imem_addr  in  64  fetch address
- imem_addr_valid  in  1  fetch request level; held until imem_data_valid or withdrawn
- imem_data  out  64  fetched data
- imem_data_valid  out  1  one-cycle fetch completion pulse
- dmem_addr  in  64  data address
- dmem_dout  in  64  store data from CPU
- dmem_write_width  in  2  00 byte, 01 half, 10 word, 11 dword
- dmem_rstrobe  in  1  load request level; held until dmem_cycle_complete
- dmem_wstrobe  in  1  store request level; held until dmem_cycle_complete
- dmem_din  out  64  load data to CPU
- dmem_cycle_complete  out  1  one-cycle data completion pulse
- bus_addr  out  64  external address
- bus_wdata  out  64  external write data
- bus_width  out  2  access width; fetch always 11
- bus_rd  out  1  external read strobe, held until bus_ack
- bus_wr  out  1  external write strobe, held until bus_ack
- bus_rdata  in  64  external read data, valid with bus_ack
- bus_ack  in  1  external completion; single cycle

## Operation
- States:
  - IDLE: sample requests.
  - IBUS: fetch transaction on the bus.
  - DBUS: data transaction on the bus.
  - RESP: drive the response pulse, then return to IDLE.
- Grant in IDLE:
  - dmem request (rstrobe|wstrobe) wins, unless starve_cnt == STARVE_LIMIT and imem_addr_valid is high.
  - Otherwise imem wins if imem_addr_valid is high.
  - Otherwise stay in IDLE.
- rstrobe and wstrobe both high is illegal. The store is performed and the load is ignored. Bench asserts this never happens.
- On grant, the address, width, wdata and a req_tag (I or D) are latched. Bus outputs drive only from the latched values.
- starve_cnt:
  - Increments on each dmem grant while imem_addr_valid is high.
  - Clears on any imem grant, or when imem_addr_valid is low.
  - Saturates at STARVE_LIMIT.
- bus_ack in IBUS/DBUS: bus_rdata is captured and the FSM moves to RESP.
- RESP, I:
  - Pulse imem_data_valid only if imem_addr_valid is still high and imem_addr equals the latched address.
  - Otherwise discard the data (jump cancelled the fetch); no pulse.
  - A new or changed request is re-arbitrated from IDLE.
- RESP, D: pulse dmem_cycle_complete. dmem_din holds the captured data for loads and is unchanged for stores.
- Requests withdrawn mid-transaction do not abort the bus cycle. It completes and is discarded (I) or still completed (D).
- imem_data and dmem_din hold their last value between pulses.
- bus_ack in IDLE or RESP is ignored.

## Timing
- Reset values:
  - bus_rd, bus_wr, imem_data_valid, dmem_cycle_complete: 0.
  - bus_addr, bus_wdata, imem_data, dmem_din: 0.
  - bus_width: 0.
  - state IDLE, starve_cnt 0.
- Reset mid-transaction drops the transaction; the external slave shares rst_n.
- Request seen in IDLE at cycle N:
  - Strobe asserted from N+1 and held until the cycle in which bus_ack is sampled (cycle M).
  - Strobe deasserted at M+1.
  - Response pulse at M+1.
- Back-to-back operation:
  - FSM is back in IDLE at M+2.
  - Next strobe earliest at M+3.
- Zero-wait bus (ack at N+1): request-to-response latency is 2 cycles; throughput is one access per 3 cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared raisin64 package holds:
  - the width encodings: WIDTH_BYTE/HALF/WORD/DWORD;
  - the arb_state_t enum: IDLE/IBUS/DBUS/RESP.
- Single module; no sub-module. The starvation counter and FSM are inline.

## Test plan
- Single fetch, imem_addr=0x1000, bus acks 2 cycles after strobe: bus_rd with bus_width=11 and bus_addr=0x1000; imem_data_valid pulses once with bus_rdata=0xDEADBEEF.
- Simultaneous imem (0x2000) and dmem store (0x3000, dword), STARVE_LIMIT=4, starve_cnt=0: store is granted first (bus_wr, bus_wdata=dmem_dout); fetch is granted next.
- Continuous dmem loads with imem held valid: exactly 4 dmem grants, then the imem grant; fetch completes before the 5th load.
- Fetch 0x1000 in flight, imem_addr changes to 0x4000 before ack: no imem_data_valid for 0x1000; a new bus_rd to 0x4000 follows; pulse carries the 0x4000 data.
- rst_n asserted while bus_rd is high mid-wait: all outputs 0 immediately; after release, a fresh request is granted normally.
- Zero-wait bus, back-to-back loads: dmem_cycle_complete pulses every 3 cycles; a late stray bus_ack in IDLE is ignored.
